// File: rtl/apb_cmd_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is enabled with `define APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   state_t            state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // The abort fires in the ACCESS cycle whose wait would bring the count to the limit.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_timeout_q, rsp_timeout_d;
`endif

   // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready,
   // a response on an edge where rsp_valid && rsp_ready; both sides hold until then.
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      cnt_d         = cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               paddr_d   = cmd_addr;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         S_ACCESS: begin
            if (pready) begin
               rsp_rdata_d = pwrite_q ? '0 : prdata;
               rsp_err_d   = pslverr;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
            end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign cmd_ready = cmd_ready_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master (TIMEOUT_CYCLES=4).
module tb_apb_cmd_master;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              pclk = 1'b0;
   logic              presetn = 1'b0;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DATA_W-1:0] rsp_rdata;
   logic              psel, penable, pwrite, pready, pslverr;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata, prdata;
   logic [1:0]        dbg_state;

   int total = 0;
   int bad   = 0;
   logic [127:0] got, exp;

   apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 pclk = ~pclk;

   // penable without psel is never legal
   always @(negedge pclk) begin
      if (presetn) begin
         total++;
         if (penable && !psel) begin
            bad++;
            $display("FAIL inv_penable_psel got psel=%0b penable=%0b exp psel=1", psel, penable);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   task automatic drop_cmd();
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drop_cmd();
      rsp_ready = 1'b1;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      presetn = 1'b0;
      #12;
      got = 128'({cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err,
                  rsp_timeout, rsp_rdata, dbg_state});
      exp = '0;
      total++;
      if (got !== exp) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
      @(negedge pclk);
      presetn = 1'b1;
      tick();
      got = 128'({cmd_ready, psel, penable, dbg_state});
      exp = 128'({1'b1, 1'b0, 1'b0, 2'd0});
      total++;
      if (got !== exp) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
   endtask

   task automatic test_write_zero_wait();
      pready = 1'b1; pslverr = 1'b0; prdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
      drive_cmd(1'b1, 10'h001, 32'hDEAD_BEEF);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", cmd_ready); end
      tick();
      drop_cmd();
      got = 128'({psel, penable, pwrite, paddr, pwdata, cmd_ready, rsp_valid, dbg_state});
      exp = 128'({1'b1, 1'b0, 1'b1, 10'h001, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd1});
      total++;
      if (got !== exp) begin bad++; $display("FAIL wr_setup got=%h exp=%h", got, exp); end
      tick();
      got = 128'({psel, penable, pwrite, paddr, pwdata, cmd_ready, rsp_valid, dbg_state});
      exp = 128'({1'b1, 1'b1, 1'b1, 10'h001, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd2});
      total++;
      if (got !== exp) begin bad++; $display("FAIL wr_access got=%h exp=%h", got, exp); end
      tick();
      got = 128'({psel, penable, paddr, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, dbg_state});
      exp = 128'({1'b0, 1'b0, 10'h001, 1'b1, 1'b0, 1'b0, 32'h0, 2'd3});
      total++;
      if (got !== exp) begin bad++; $display("FAIL wr_rsp got=%h exp=%h", got, exp); end
      tick();
      got = 128'({rsp_valid, cmd_ready, psel, dbg_state});
      exp = 128'({1'b0, 1'b1, 1'b0, 2'd0});
      total++;
      if (got !== exp) begin bad++; $display("FAIL wr_idle got=%h exp=%h", got, exp); end
   endtask

   task automatic test_read_wait_states();
      pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
      drive_cmd(1'b0, 10'h002, 32'h0);
      tick();
      drop_cmd();
      got = 128'({psel, penable, pwrite, paddr});
      exp = 128'({1'b1, 1'b0, 1'b0, 10'h002});
      total++;
      if (got !== exp) begin bad++; $display("FAIL rd_setup got=%h exp=%h", got, exp); end
      tick();
      for (int i = 0; i < 4; i++) begin
         got = 128'({psel, penable, pwrite, paddr, rsp_valid});
         exp = 128'({1'b1, 1'b1, 1'b0, 10'h002, 1'b0});
         total++;
         if (got !== exp) begin bad++; $display("FAIL rd_access%0d got=%h exp=%h", i, got, exp); end
         if (i == 3) begin
            pready = 1'b1;
            prdata = 32'h0000_00A5;
         end
         tick();
      end
      prdata = 32'h1111_1111;
      got = 128'({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00A5});
      total++;
      if (got !== exp) begin bad++; $display("FAIL rd_rsp got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_slave_error();
      // pslverr while waiting is ignored
      pready = 1'b0; pslverr = 1'b1; prdata = 32'h0; rsp_ready = 1'b1;
      drive_cmd(1'b0, 10'h003, 32'h0);
      tick();
      drop_cmd();
      tick();
      pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_0011;
      tick();
      got = 128'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b1, 1'b0, 1'b0, 32'h0000_0011});
      total++;
      if (got !== exp) begin bad++; $display("FAIL err_ignored got=%h exp=%h", got, exp); end
      tick();
      pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_0022;
      drive_cmd(1'b0, 10'h004, 32'h0);
      tick();
      drop_cmd();
      tick();
      tick();
      pslverr = 1'b0;
      got = 128'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b1, 1'b1, 1'b0, 32'h0000_0022});
      total++;
      if (got !== exp) begin bad++; $display("FAIL err_seen got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_back_to_back();
      pready = 1'b1; pslverr = 1'b0; prdata = 32'hCAFE_0001; rsp_ready = 1'b0;
      drive_cmd(1'b0, 10'h3FF, 32'h0);
      tick();
      drop_cmd();
      tick();
      tick();
      prdata = 32'h0;
      drive_cmd(1'b1, 10'h155, 32'h0BAD_F00D);
      for (int i = 0; i < 5; i++) begin
         got = 128'({rsp_valid, rsp_rdata, cmd_ready, psel, paddr, pwrite});
         exp = 128'({1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 10'h3FF, 1'b0});
         total++;
         if (got !== exp) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", i, got, exp); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      got = 128'({rsp_valid, cmd_ready, psel, paddr});
      exp = 128'({1'b0, 1'b1, 1'b0, 10'h3FF});
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_release got=%h exp=%h", got, exp); end
      tick();
      drop_cmd();
      got = 128'({psel, penable, pwrite, paddr, pwdata});
      exp = 128'({1'b1, 1'b0, 1'b1, 10'h155, 32'h0BAD_F00D});
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_next_setup got=%h exp=%h", got, exp); end
      tick();
      tick();
      got = 128'({rsp_valid, rsp_err, rsp_rdata});
      exp = 128'({1'b1, 1'b0, 32'h0});
      total++;
      if (got !== exp) begin bad++; $display("FAIL bp_next_rsp got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_reset_mid_access();
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; rsp_ready = 1'b1;
      drive_cmd(1'b0, 10'h0F0, 32'h0);
      tick();
      drop_cmd();
      tick();
      total++;
      if (penable !== 1'b1) begin bad++; $display("FAIL rst_pre_access got=%b exp=1", penable); end
      #2;
      presetn = 1'b0;
      #1;
      got = 128'({psel, penable, rsp_valid, cmd_ready, paddr, dbg_state});
      exp = '0;
      total++;
      if (got !== exp) begin bad++; $display("FAIL rst_async got=%h exp=%h", got, exp); end
      @(negedge pclk);
      presetn = 1'b1;
      pready  = 1'b1;
      tick();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
      drive_cmd(1'b1, 10'h010, 32'h55AA_55AA);
      tick();
      drop_cmd();
      tick();
      got = 128'({psel, penable, pwrite, paddr, pwdata});
      exp = 128'({1'b1, 1'b1, 1'b1, 10'h010, 32'h55AA_55AA});
      total++;
      if (got !== exp) begin bad++; $display("FAIL rst_fresh_access got=%h exp=%h", got, exp); end
      tick();
      got = 128'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b1, 1'b0, 1'b0, 32'h0});
      total++;
      if (got !== exp) begin bad++; $display("FAIL rst_fresh_rsp got=%h exp=%h", got, exp); end
      tick();
   endtask

   task automatic test_timeout();
      int dropped;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0000_DDDD; rsp_ready = 1'b1;
      dropped = 0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      drive_cmd(1'b0, 10'h020, 32'h0);
      tick();
      drop_cmd();
      tick();
      for (int i = 0; i < 4; i++) begin
         if (!(psel && penable)) dropped++;
         tick();
      end
      total++;
      if (dropped != 0) begin bad++; $display("FAIL to_wait got=%0d drops exp=0", dropped); end
      got = 128'({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0});
      total++;
      if (got !== exp) begin bad++; $display("FAIL to_abort got=%h exp=%h", got, exp); end
      tick();
      drive_cmd(1'b0, 10'h021, 32'h0);
      tick();
      drop_cmd();
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            pready = 1'b1;
            prdata = 32'h0000_005A;
         end
         tick();
      end
      got = 128'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b1, 1'b0, 1'b0, 32'h0000_005A});
      total++;
      if (got !== exp) begin bad++; $display("FAIL to_race got=%h exp=%h", got, exp); end
      tick();
`else
      drive_cmd(1'b0, 10'h022, 32'h0);
      tick();
      drop_cmd();
      tick();
      for (int i = 0; i < 120; i++) begin
         if (!(psel && penable && !rsp_valid)) dropped++;
         tick();
      end
      total++;
      if (dropped != 0) begin bad++; $display("FAIL nto_wait got=%0d drops exp=0", dropped); end
      pready = 1'b1;
      prdata = 32'h0000_005A;
      tick();
      got = 128'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
      exp = 128'({1'b1, 1'b0, 1'b0, 32'h0000_005A});
      total++;
      if (got !== exp) begin bad++; $display("FAIL nto_rsp got=%h exp=%h", got, exp); end
      tick();
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait_states();
      test_slave_error();
      test_back_to_back();
      test_reset_mid_access();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
